decompress_stream: RTL and testbench

//  Streaming inverse of the per-element float compressor. Accepts packed groups (one 32-bit bitmap word, then byte-packed payload), and

---
 rtl/decomp_pkg.sv | 33 +++
 rtl/decompress_lane.sv | 51 +++++
 rtl/decompress_stream.sv | 113 +++++++++++
 tb/tb_decompress_stream.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/decomp_pkg.sv
// Shared constants, element codes and payload sizing helpers for the
// per-element float decompressor.
package decomp_pkg;

  localparam int GROUP     = 16;
  localparam int BUF_BYTES = 8;

  localparam logic [1:0] BM_ZERO = 2'b00;
  localparam logic [1:0] BM_8    = 2'b01;
  localparam logic [1:0] BM_16   = 2'b10;
  localparam logic [1:0] BM_32   = 2'b11;

  typedef enum logic {HDR, ELEM} state_t;

  function automatic logic [2:0] bm_bytes(input logic [1:0] code);
    case (code)
      BM_ZERO: return 3'd0;
      BM_8:    return 3'd1;
      BM_16:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Payload words of a group: total element bytes rounded up to a whole word.
  function automatic logic [4:0] payload_words(input logic [31:0] bitmap);
    logic [6:0] total;
    total = '0;
    for (int i = 0; i < GROUP; i++)
      total = total + {4'b0, bm_bytes(bitmap[2*i +: 2])};
    return 5'((total + 7'd3) >> 2);
  endfunction

endpackage

// File: rtl/decompress_lane.sv
// Combinational decode of one compressed element (code plus up to four
// little-endian payload bytes) into its reconstructed 32-bit word.
module decompress_lane
  import decomp_pkg::*;
(
  input  logic [1:0]  code,
  input  logic [31:0] bytes,
  output logic [31:0] data
);

  logic        sign;
  logic [14:0] frac;
  logic [7:0]  exp_base;
  logic [3:0]  lead;
  logic [22:0] mant;
  logic [31:0] fp;

  // The leading one of the code becomes the implicit bit; bits below it
  // are left-justified into the mantissa.
  always_comb begin
    sign     = 1'b0;
    frac     = '0;
    exp_base = '0;
    lead     = '0;
    mant     = '0;
    fp       = '0;
    data     = '0;
    case (code)
      BM_ZERO: data = '0;
      BM_32:   data = bytes;
      default: begin
        if (code == BM_8) begin
          sign     = bytes[7];
          frac     = {8'b0, bytes[6:0]};
          exp_base = 8'd120;
        end else begin
          sign     = bytes[15];
          frac     = bytes[14:0];
          exp_base = 8'd112;
        end
        for (int i = 0; i < 15; i++)
          if (frac[i]) lead = 4'(i);
        mant = {8'b0, frac} << (5'd23 - {1'b0, lead});
        if (frac == '0) fp = {sign, 31'b0};
        else            fp = {sign, exp_base + {4'b0, lead}, mant};
        data = {fp[7:0], fp[15:8], fp[23:16], fp[31:24]};
      end
    endcase
  end

endmodule

// File: rtl/decompress_stream.sv
// Streaming group decompressor: bitmap word, then byte-packed payload, out
// comes 16 words per group. Define DECOMP_PAD_CHECK_EN for sticky pad checking.
module decompress_stream
  import decomp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        pad_err
);

  state_t                   state;
  logic [31:0]              bitmap;
  logic [4:0]               words_left;
  logic [3:0]               elem;
  logic [BUF_BYTES*8-1:0]   byte_buf;
  logic [3:0]               count;

  logic [1:0]               code;
  logic [2:0]               need;
  logic [2:0]               used;
  logic                     accept;
  logic                     emit;
  logic                     group_end;
  logic [BUF_BYTES*8-1:0]   shifted;
  logic [BUF_BYTES*8-1:0]   appended;
  logic [31:0]              lane_data;

  // Bytes of the head element are consumed from the bottom of the aligner
  // while a new word lands directly above whatever remains.
  always_comb begin
    code      = bitmap[{elem, 1'b0} +: 2];
    need      = bm_bytes(code);
    in_ready  = (state == HDR) || ((words_left != '0) && (count <= 4'd4));
    accept    = in_valid && in_ready;
    emit      = (state == ELEM) && ({1'b0, need} <= count) && (!out_valid || out_ready);
    group_end = emit && (elem == 4'(GROUP - 1));
    used      = emit ? need : 3'd0;
    shifted   = byte_buf >> {used, 3'b0};
    appended  = shifted | ({32'b0, in_data} << {count - {1'b0, used}, 3'b0});
  end

  decompress_lane u_lane (
    .code  (code),
    .bytes (byte_buf[31:0]),
    .data  (lane_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HDR;
      bitmap     <= '0;
      words_left <= '0;
      elem       <= '0;
      byte_buf   <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
    end else begin
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= lane_data;
        out_last  <= group_end;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        HDR: begin
          if (accept) begin
            bitmap     <= in_data;
            words_left <= payload_words(in_data);
            elem       <= '0;
            state      <= ELEM;
          end
        end
        ELEM: begin
          if (accept) words_left <= words_left - 5'd1;
          // Whatever is left after the last element is pad and is dropped.
          if (group_end) begin
            byte_buf <= '0;
            count    <= '0;
            state    <= HDR;
          end else begin
            byte_buf <= accept ? appended : shifted;
            count    <= count - {1'b0, used} + (accept ? 4'd4 : 4'd0);
            if (emit) elem <= elem + 4'd1;
          end
        end
        default: state <= HDR;
      endcase
    end
  end

`ifdef DECOMP_PAD_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pad_err <= 1'b0;
    else if (group_end && (shifted != '0))
      pad_err <= 1'b1;
  end
`else
  assign pad_err = 1'b0;
`endif

endmodule

// File: tb/tb_decompress_stream.sv
// Self-checking bench for decompress_stream: table of whole groups plus
// hand sequences for backpressure, input stalls, mid-group reset and pad errors.
module tb_decompress_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;
  logic        pad_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0]       bitmap;
    logic [4:0]        npay;
    logic [15:0][31:0] pay;
    logic [15:0][31:0] exp;
  } vec_t;

  vec_t vecs [7];

  decompress_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .pad_err   (pad_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Offer one word and hold it until the DUT takes it; in_ready is sampled
  // on the falling edge, so the following rising edge is the handshake.
  task automatic send_word(input logic [31:0] w, output logic ok);
    int t;
    t  = 0;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (in_ready) begin
      @(posedge clk);
      ok = 1'b1;
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int g, input vec_t v, input int stall_at);
    int accepted;
    accepted = 0;
    fork
      begin
        logic ok;
        send_word(v.bitmap, ok);
        if (ok) accepted++;
        for (int i = 0; i < int'(v.npay); i++) begin
          send_word(v.pay[i], ok);
          if (ok) accepted++;
        end
      end
      begin
        int          got;
        int          cyc;
        logic        hold;
        logic [31:0] held;
        got  = 0;
        cyc  = 0;
        hold = 1'b0;
        held = '0;
        while (got < 16 && cyc < 2000) begin
          @(negedge clk);
          cyc++;
          if (hold) begin
            checkOutput($sformatf("grp%0d hold valid", g), 32'(out_valid), 32'd1);
            checkOutput($sformatf("grp%0d hold data", g), out_data, held);
          end
          out_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5);
          if (out_valid && out_ready) begin
            checkOutput($sformatf("grp%0d out%0d data", g, got), out_data, v.exp[got]);
            checkOutput($sformatf("grp%0d out%0d last", g, got), 32'(out_last),
                        32'(got == 15));
            got++;
          end
          hold = out_valid && !out_ready;
          held = out_data;
        end
        checkOutput($sformatf("grp%0d output count", g), 32'(got), 32'd16);
      end
    join
    out_ready = 1'b1;
    checkOutput($sformatf("grp%0d words accepted", g), 32'(accepted), 32'(v.npay) + 32'd1);
  endtask

  initial begin
    logic ok;
    int   n;

    for (int g = 0; g < 7; g++) vecs[g] = '0;
    // All raw: payload words come back untouched.
    vecs[0].bitmap = 32'hFFFF_FFFF;
    vecs[0].npay   = 5'd16;
    for (int i = 0; i < 16; i++) begin
      vecs[0].pay[i] = 32'(i);
      vecs[0].exp[i] = 32'(i);
    end
    // All zero elements, no payload.
    vecs[1].bitmap = 32'h0000_0000;
    vecs[1].npay   = 5'd0;
    // code8 0x40 -> 0.5f.
    vecs[2].bitmap = 32'h0000_0001;
    vecs[2].npay   = 5'd1;
    vecs[2].pay[0] = 32'h0000_0040;
    vecs[2].exp[0] = 32'h0000_003F;
    // code16 0x8001 -> -2^-15.
    vecs[3].bitmap = 32'h0000_0002;
    vecs[3].npay   = 5'd1;
    vecs[3].pay[0] = 32'h0000_8001;
    vecs[3].exp[0] = 32'h0000_00B8;
    // raw, code8, raw, raw straddling word boundaries.
    vecs[4].bitmap = 32'h0000_00F7;
    vecs[4].npay   = 5'd4;
    vecs[4].pay[0] = 32'h4433_2211;
    vecs[4].pay[1] = 32'hCCBB_AA40;
    vecs[4].pay[2] = 32'h6543_21DD;
    vecs[4].pay[3] = 32'h0000_0087;
    vecs[4].exp[0] = 32'h4433_2211;
    vecs[4].exp[1] = 32'h0000_003F;
    vecs[4].exp[2] = 32'hDDCC_BBAA;
    vecs[4].exp[3] = 32'h8765_4321;
    // code8 0x85, code16 0x1234, code8 -0, zero, code16 +0, raw.
    vecs[5].bitmap = 32'h0000_0E19;
    vecs[5].npay   = 5'd3;
    vecs[5].pay[0] = 32'h8012_3485;
    vecs[5].pay[1] = 32'hBABE_0000;
    vecs[5].pay[2] = 32'h0000_CAFE;
    vecs[5].exp[0] = 32'h0000_20BD;
    vecs[5].exp[1] = 32'h00A0_113E;
    vecs[5].exp[2] = 32'h0000_0080;
    vecs[5].exp[5] = 32'hCAFE_BABE;
    // code8 0x40 followed by a non-zero pad byte.
    vecs[6].bitmap = 32'h0000_0001;
    vecs[6].npay   = 5'd1;
    vecs[6].pay[0] = 32'h005A_0040;
    vecs[6].exp[0] = 32'h0000_003F;

    repeat (3) @(negedge clk);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_data", out_data, 32'd0);
    checkOutput("reset out_last", 32'(out_last), 32'd0);
    checkOutput("reset pad_err", 32'(pad_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);

    for (int g = 0; g < 6; g++)
      applyStimulus(g, vecs[g], (g == 4) ? 5 : -1);

    // Zero bitmap: no payload is requested while its elements drain.
    send_word(32'h0000_0000, ok);
    checkOutput("zero hdr accepted", 32'(ok), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput($sformatf("zero hdr in_ready %0d", i), 32'(in_ready), 32'd0);
    end
    n = 0;
    while (!(out_valid && out_last) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("zero hdr last seen", 32'(out_valid && out_last), 32'd1);
    checkOutput("zero hdr back to header", 32'(in_ready), 32'd1);
    @(negedge clk);
    checkOutput("pad_err clean groups", 32'(pad_err), 32'd0);

    // Abandon a group part-way through with a reset.
    send_word(32'hFFFF_FFFF, ok);
    for (int i = 0; i < 3; i++) send_word(32'h1111_0000 + 32'(i), ok);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid reset out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid reset in_ready", 32'(in_ready), 32'd1);

    applyStimulus(6, vecs[6], -1);
    @(negedge clk);
`ifdef DECOMP_PAD_CHECK_EN
    checkOutput("pad_err set", 32'(pad_err), 32'd1);
    @(negedge clk);
    checkOutput("pad_err sticky", 32'(pad_err), 32'd1);
`else
    checkOutput("pad_err tied", 32'(pad_err), 32'd0);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("pad_err cleared", 32'(pad_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
